// File: rtl/fp_check_pkg.sv
// Shared types and constants for the fp_unit result checker.
// Entry layout, checker state encoding and the canonical-NaN patterns.
package fp_wire;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic [1:0]  fmt;
        logic        mask;
    } fp_check_entry;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAIL,
        DONE
    } fp_check_state;

    localparam logic [63:0] FP_CANON_NAN_S = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] FP_CANON_NAN_D = 64'h7FF8_0000_0000_0000;

    // Result XOR with sign and payload ignored when the unit returned the canonical NaN.
    function automatic logic [63:0] fp_masked_diff(input fp_check_entry exp_e,
                                                   input logic [63:0]   calc);
        logic [63:0] d;
        d = exp_e.result ^ calc;
        if (exp_e.mask && exp_e.fmt == 2'd0 && calc == FP_CANON_NAN_S) begin
            d[21:0]  = '0;
            d[63:31] = '0;
        end else if (exp_e.mask && exp_e.fmt == 2'd1 && calc == FP_CANON_NAN_D) begin
            d[50:0]  = '0;
            d[63]    = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/fp_check_fifo.sv
// Synchronous FIFO of expected-result entries.
// Pointers carry an extra wrap bit so full and empty come straight from the pointers.
module fp_check_fifo
    import fp_wire::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  fp_check_entry push_data,
    input  logic          pop,
    output fp_check_entry head,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    fp_check_entry mem [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_comb begin
        head  = mem[rd_ptr[AW-1:0]];
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    end

endmodule

// File: rtl/fp_check.sv
// In-order result checker for fp_unit: queues expectations, compares retired results,
// counts passes and freezes with a snapshot on the first mismatch.
module fp_check
    import fp_wire::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [63:0] exp_result,
    input  logic [4:0]  exp_flags,
    input  logic [1:0]  exp_fmt,
    input  logic        exp_mask,
    input  logic        res_valid,
    input  logic [63:0] res_result,
    input  logic [4:0]  res_flags,
    input  logic        end_i,
    output logic [31:0] pass_count,
    output logic        fail,
    output logic        underflow,
    output logic        done,
    output logic [31:0] fail_index,
    output logic [63:0] fail_exp_result,
    output logic [63:0] fail_calc_result,
    output logic [63:0] fail_diff,
    output logic [4:0]  fail_exp_flags,
    output logic [4:0]  fail_calc_flags
);

    fp_check_state state;
    fp_check_state state_next;

    fp_check_entry push_entry;
    fp_check_entry head;
    logic          full;
    logic          empty;
    logic          active;
    logic          push;
    logic          pop;
    logic          underflow_evt;
    logic [63:0]   diff;
    logic [4:0]    flag_diff;
    logic          match;

    assign push_entry = '{result: exp_result, flags: exp_flags, fmt: exp_fmt, mask: exp_mask};

    fp_check_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        diff      = fp_masked_diff(head, res_result);
        flag_diff = head.flags ^ res_flags;
        match     = (diff == '0) && (flag_diff == '0);
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (underflow_evt)
                    state_next = FAIL;
                else if (push)
                    state_next = RUN;
            end
            RUN: begin
                if (underflow_evt)
                    state_next = FAIL;
                else if (pop && !match)
                    state_next = FAIL;
                else if (!res_valid && end_i && empty)
                    state_next = DONE;
            end
            FAIL:    state_next = FAIL;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        active        = (state == IDLE) || (state == RUN);
        exp_ready     = active && !full;
        done          = (state == DONE);
        push          = exp_valid && exp_ready;
        pop           = res_valid && (state == RUN) && !empty;
        underflow_evt = res_valid && active && empty;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pass_count       <= '0;
            fail             <= 1'b0;
            underflow        <= 1'b0;
            fail_index       <= '0;
            fail_exp_result  <= '0;
            fail_calc_result <= '0;
            fail_diff        <= '0;
            fail_exp_flags   <= '0;
            fail_calc_flags  <= '0;
        end else begin
            if (pop) begin
                if (match) begin
                    pass_count <= pass_count + 32'd1;
                end else begin
                    fail             <= 1'b1;
                    fail_index       <= pass_count;
                    fail_exp_result  <= head.result;
                    fail_calc_result <= res_result;
                    fail_diff        <= diff;
                    fail_exp_flags   <= head.flags;
                    fail_calc_flags  <= res_flags;
                end
            end
            if (underflow_evt)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_check.sv
// Self-checking bench for fp_check: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fp_check;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [63:0] result;
        logic [4:0]  flags;
        logic [1:0]  fmt;
        logic        mask;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_ready;
    logic [63:0] exp_result = '0;
    logic [4:0]  exp_flags = '0;
    logic [1:0]  exp_fmt = '0;
    logic        exp_mask = 1'b0;
    logic        res_valid = 1'b0;
    logic [63:0] res_result = '0;
    logic [4:0]  res_flags = '0;
    logic        end_i = 1'b0;
    logic [31:0] pass_count;
    logic        fail;
    logic        underflow;
    logic        done;
    logic [31:0] fail_index;
    logic [63:0] fail_exp_result;
    logic [63:0] fail_calc_result;
    logic [63:0] fail_diff;
    logic [4:0]  fail_exp_flags;
    logic [4:0]  fail_calc_flags;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    fp_check #(
        .DEPTH (DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .exp_valid        (exp_valid),
        .exp_ready        (exp_ready),
        .exp_result       (exp_result),
        .exp_flags        (exp_flags),
        .exp_fmt          (exp_fmt),
        .exp_mask         (exp_mask),
        .res_valid        (res_valid),
        .res_result       (res_result),
        .res_flags        (res_flags),
        .end_i            (end_i),
        .pass_count       (pass_count),
        .fail             (fail),
        .underflow        (underflow),
        .done             (done),
        .fail_index       (fail_index),
        .fail_exp_result  (fail_exp_result),
        .fail_calc_result (fail_calc_result),
        .fail_diff        (fail_diff),
        .fail_exp_flags   (fail_exp_flags),
        .fail_calc_flags  (fail_calc_flags)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: an expectation queue plus the checker's observable results.
    exp_t        q[$];
    bit          started = 1'b0;
    bit          stopped = 1'b0;
    logic [31:0] m_pass = '0;
    logic        m_fail = 1'b0;
    logic        m_uf = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_fidx = '0;
    logic [63:0] m_fexp = '0;
    logic [63:0] m_fcalc = '0;
    logic [63:0] m_fdiff = '0;
    logic [4:0]  m_fef = '0;
    logic [4:0]  m_fcf = '0;

    function automatic logic m_ready();
        return !stopped && (q.size() < DEPTH);
    endfunction

    always @(posedge clock) begin
        exp_t        e;
        exp_t        n;
        logic [63:0] dd;
        bit          can_push;
        if (!reset) begin
            q.delete();
            started = 0; stopped = 0;
            m_pass = '0; m_fail = 0; m_uf = 0; m_done = 0;
            m_fidx = '0; m_fexp = '0; m_fcalc = '0; m_fdiff = '0; m_fef = '0; m_fcf = '0;
        end else if (!stopped) begin
            can_push = m_ready();
            if (res_valid) begin
                if (q.size() == 0) begin
                    m_uf = 1; stopped = 1;
                end else begin
                    e = q.pop_front();
                    dd = e.result ^ res_result;
                    if (e.mask && e.fmt == 2'd0 && res_result == 64'h0000_0000_7FC0_0000)
                        dd = dd & 64'h0000_0000_7FC0_0000;
                    else if (e.mask && e.fmt == 2'd1 && res_result == 64'h7FF8_0000_0000_0000)
                        dd = dd & 64'h7FF8_0000_0000_0000;
                    if (dd == 0 && e.flags == res_flags) begin
                        m_pass = m_pass + 1;
                    end else begin
                        m_fail = 1; stopped = 1;
                        m_fidx = m_pass; m_fexp = e.result; m_fcalc = res_result;
                        m_fdiff = dd; m_fef = e.flags; m_fcf = res_flags;
                    end
                end
            end else if (end_i && started && q.size() == 0) begin
                m_done = 1; stopped = 1;
            end
            if (exp_valid && can_push) begin
                n.result = exp_result; n.flags = exp_flags; n.fmt = exp_fmt; n.mask = exp_mask;
                q.push_back(n);
                started = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            chk("exp_ready", 64'(exp_ready), 64'(m_ready()));
            chk("pass_count", 64'(pass_count), 64'(m_pass));
            chk("fail", 64'(fail), 64'(m_fail));
            chk("underflow", 64'(underflow), 64'(m_uf));
            chk("done", 64'(done), 64'(m_done));
            chk("fail_index", 64'(fail_index), 64'(m_fidx));
            chk("fail_exp_result", fail_exp_result, m_fexp);
            chk("fail_calc_result", fail_calc_result, m_fcalc);
            chk("fail_diff", fail_diff, m_fdiff);
            chk("fail_exp_flags", 64'(fail_exp_flags), 64'(m_fef));
            chk("fail_calc_flags", 64'(fail_calc_flags), 64'(m_fcf));
        end
    end

    task automatic step(input logic ev, input logic [63:0] er, input logic [4:0] ef,
                        input logic [1:0] efmt, input logic em,
                        input logic rv, input logic [63:0] rr, input logic [4:0] rf);
        exp_valid = ev; exp_result = er; exp_flags = ef; exp_fmt = efmt; exp_mask = em;
        res_valid = rv; res_result = rr; res_flags = rf;
        @(negedge clock);
        exp_valid = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic push_e(input logic [63:0] er, input logic [4:0] ef,
                          input logic [1:0] efmt, input logic em);
        step(1'b1, er, ef, efmt, em, 1'b0, '0, '0);
    endtask

    task automatic ret_r(input logic [63:0] rr, input logic [4:0] rf);
        step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, rr, rf);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        @(posedge clock);
        armed = 1'b1;
        @(negedge clock);
        chk("reset_exp_ready", 64'(exp_ready), 64'd1);
        chk("reset_pass_count", 64'(pass_count), 64'd0);
        reset = 1'b1;

        // Three single-precision matches, then end of stream.
        for (int i = 0; i < 3; i++) push_e(64'h3F80_0000, 5'h0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) ret_r(64'h3F80_0000, 5'h0);
        chk("t1_pass_count", 64'(pass_count), 64'd3);
        end_i = 1'b1;
        @(negedge clock);
        end_i = 1'b0;
        chk("t1_done", 64'(done), 64'd1);
        do_reset();

        // Single NaN masking, then the same without masking.
        push_e(64'h7FC0_0001, 5'h0, 2'd0, 1'b1);
        ret_r(64'h7FC0_0000, 5'h0);
        chk("t2_masked_pass", 64'(pass_count), 64'd1);
        push_e(64'h7FC0_0001, 5'h0, 2'd0, 1'b0);
        ret_r(64'h7FC0_0000, 5'h0);
        chk("t2_fail", 64'(fail), 64'd1);
        chk("t2_fail_diff", fail_diff, 64'h1);
        chk("t2_fail_index", 64'(fail_index), 64'd1);
        do_reset();

        // Double NaN masking, then a flag-only mismatch.
        push_e(64'hFFF8_0000_0000_0001, 5'h0, 2'd1, 1'b1);
        ret_r(64'h7FF8_0000_0000_0000, 5'h0);
        chk("t3_masked_pass", 64'(pass_count), 64'd1);
        push_e(64'h7FF8_0000_0000_0000, 5'h10, 2'd1, 1'b1);
        ret_r(64'h7FF8_0000_0000_0000, 5'h00);
        chk("t3_fail", 64'(fail), 64'd1);
        chk("t3_fail_calc_flags", 64'(fail_calc_flags), 64'h0);
        chk("t3_fail_exp_flags", 64'(fail_exp_flags), 64'h10);
        chk("t3_fail_diff", fail_diff, 64'h0);
        do_reset();

        // Fill, drop, simultaneous push/pop, drain, then underflow.
        for (int i = 1; i <= 4; i++) push_e(64'(i), 5'h0, 2'd0, 1'b0);
        chk("t4_full_ready", 64'(exp_ready), 64'd0);
        push_e(64'h5, 5'h0, 2'd0, 1'b0);
        ret_r(64'h1, 5'h0);
        step(1'b1, 64'h6, 5'h0, 2'd0, 1'b0, 1'b1, 64'h2, 5'h0);
        chk("t4_occ3_ready", 64'(exp_ready), 64'd1);
        ret_r(64'h3, 5'h0);
        ret_r(64'h4, 5'h0);
        ret_r(64'h6, 5'h0);
        chk("t4_pass_count", 64'(pass_count), 64'd5);
        ret_r(64'h7, 5'h0);
        chk("t5_underflow", 64'(underflow), 64'd1);
        chk("t5_fail", 64'(fail), 64'd0);
        chk("t5_ready", 64'(exp_ready), 64'd0);
        do_reset();

        // end_i in IDLE is ignored; first push with a same-cycle result is an underflow.
        end_i = 1'b1;
        repeat (2) @(negedge clock);
        end_i = 1'b0;
        chk("t7_idle_done", 64'(done), 64'd0);
        step(1'b1, 64'h9, 5'h0, 2'd0, 1'b0, 1'b1, 64'h9, 5'h0);
        chk("t7_first_push_uf", 64'(underflow), 64'd1);
        do_reset();

        // Reset while frozen with entries still queued.
        push_e(64'h10, 5'h0, 2'd0, 1'b0);
        push_e(64'h20, 5'h0, 2'd0, 1'b0);
        push_e(64'h30, 5'h0, 2'd0, 1'b0);
        ret_r(64'h11, 5'h0);
        chk("t6_fail", 64'(fail), 64'd1);
        do_reset();
        chk("t6_rst_fail", 64'(fail), 64'd0);
        chk("t6_rst_diff", fail_diff, 64'h0);
        chk("t6_rst_ready", 64'(exp_ready), 64'd1);
        push_e(64'h40, 5'h3, 2'd0, 1'b0);
        ret_r(64'h40, 5'h3);
        chk("t6_pass_count", 64'(pass_count), 64'd1);

        @(negedge clock);
        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_check.md
# fp_check

Result checker sitting directly downstream of `fp_unit`. It queues the expected result and flags for every operation issued to the unit, then pops and compares them in order as `fp_unit` retires results. Comparison masks canonical-NaN payload and sign differences. The block counts passes and failures, freezes on the first mismatch and reports completion, so vector runs can be checked in hardware or emulation without a behavioural bench.

## Interface
- `DEPTH`, default 4: number of expected-result FIFO entries, power of two, minimum 2.
- `clock  in  1`: clock.
- `reset  in  1`: synchronous, active-low.
- `exp_valid  in  1`: an operation is issued to `fp_unit` this cycle; push its expectation.
- `exp_ready  out  1`: FIFO can accept a push.
- `exp_result  in  64`: expected result.
- `exp_flags  in  5`: expected flags, NV DZ OF UF NX.
- `exp_fmt  in  2`: 0 = single, 1 = double.
- `exp_mask  in  1`: 1 = apply canonical-NaN masking to this entry.
- `res_valid  in  1`: `fp_unit` result valid this cycle.
- `res_result  in  64`: calculated result.
- `res_flags  in  5`: calculated flags.
- `end_i  in  1`: stimulus stream exhausted (level).
- `pass_count  out  32`: number of matching compares.
- `fail  out  1`: sticky mismatch.
- `underflow  out  1`: sticky; a result arrived with no expectation queued.
- `done  out  1`: run completed without failure.
- `fail_index  out  32`: compare index (0-based) of the first mismatch.
- `fail_exp_result  out  64`, `fail_calc_result  out  64`: values at the first mismatch.
- `fail_diff  out  64`: masked XOR at the first mismatch.
- `fail_exp_flags  out  5`, `fail_calc_flags  out  5`: flag values at the first mismatch.

## Operation
- States:
  - IDLE: entered on reset. First push → RUN.
  - RUN: normal checking.
  - FAIL: terminal until reset.
  - DONE: terminal until reset.
- Push:
  - Accepted when `exp_valid & exp_ready`.
  - `exp_ready = !full` in IDLE and RUN; 0 in FAIL and DONE.
  - A push while not ready is dropped.
- Pop: on `res_valid` in RUN, pop the head entry and compare it against the result.
  - Result diff = `exp_result ^ res_result`.
  - Single-precision NaN masking: if `mask` is set, `fmt` = 0 and `res_result` = 0x000000007FC00000, clear diff bits [21:0] and [63:31].
  - Double-precision NaN masking: if `mask` is set, `fmt` = 1 and `res_result` = 0x7FF8000000000000, clear diff bits [50:0] and bit [63].
  - Flag diff = `exp_flags ^ res_flags`. Flags are never masked.
  - Match: both diffs are zero → `pass_count`+1.
  - Mismatch: capture all `fail_*` outputs, set `fail`, → FAIL.
- `fail_index` equals `pass_count` at the moment of the mismatch.
- Underflow: `res_valid` with the FIFO empty (in IDLE or RUN) sets `underflow` and → FAIL. `fail` stays 0 and the `fail_*` values are unchanged.
- DONE: `end_i` = 1 and the FIFO empty and no `res_valid` in RUN → DONE, `done` = 1. In IDLE, `end_i` does not cause a transition.
- Push and pop in the same cycle with a non-empty FIFO: both take effect and occupancy is unchanged. The popped entry is the old head.
- `res_valid` in FAIL or DONE is ignored; counters are frozen.
- `pass_count` wraps at 2^32 with no flag.

## Timing
- Reset values: `exp_ready` = 1; all other outputs 0; FIFO empty; state IDLE.
- Reset has priority over all events. Reset mid-run empties the FIFO and clears all outputs on the next edge.
- `fp_unit` latency is at least 1 cycle. An expectation pushed in cycle N cannot be popped before cycle N+1. A `res_valid` in the same cycle as the first push into an empty FIFO is an underflow.
- Compare is registered. `pass_count`, `fail`, `fail_*` and the state update at the clock edge following `res_valid`.
- `done` and `underflow` also assert one edge after their condition.
- `exp_ready` is combinational from the registered occupancy and state. It deasserts in the cycle after the push that fills the FIFO.

## Structure
- Shared package `fp_wire` gets:
  - typedef `fp_check_entry`: result[63:0], flags[4:0], fmt[1:0], mask.
  - enum `fp_check_state`: IDLE, RUN, FAIL, DONE.
  - constants `FP_CANON_NAN_S` = 0x000000007FC00000 and `FP_CANON_NAN_D` = 0x7FF8000000000000.
- Sub-module `fp_check_fifo`: synchronous FIFO of `fp_check_entry`.
  - Read and write pointers carry an extra wrap bit.
  - Full and empty are derived from the pointers.
  - Simultaneous push and pop are supported.
- Top level holds the state machine, the masking/compare logic and the capture registers.

## Test plan
- Push 3 entries with `fmt` = 0, `mask` = 1, expecting 0x3F800000 and flags 0. Return all three exactly → `pass_count` = 3; then `end_i` → `done` = 1 one cycle later.
- Expect 0x000000007FC00001, return 0x000000007FC00000 (`fmt` = 0, `mask` = 1) → pass. Repeat with `mask` = 0 → `fail`, `fail_diff` = 0x1, `fail_index` = 1.
- Double precision: expect 0xFFF8000000000001, return 0x7FF8000000000000 with `mask` = 1 → pass. Expect flags 0x10, return flags 0x00 → `fail`, `fail_calc_flags` = 0x00.
- Fill all `DEPTH` = 4 entries → `exp_ready` = 0; a fifth push is dropped. Push and pop in the same cycle at occupancy 3 → occupancy stays 3 and order is preserved.
- `res_valid` with the FIFO empty → `underflow` = 1, `fail` = 0, state FAIL, `exp_ready` = 0.
- Assert reset while in FAIL with 2 entries queued → all outputs 0, `exp_ready` = 1. A following push and matching result → `pass_count` = 1.
